morse_sequence_player: RTL and testbench

- Reads the 10-bit encoded letter that sequence_producer emits and keys it out as timed Morse on/off signalling on a single line (LED/buzzer).
- It sits downstream of sequence_producer and is driven by that block's EncSeq, Space_EndSeqbar and SentFlag.
- Standard Morse unit timing applies: dot 1 unit, dash 3 units, intra-letter gap 1 unit, letter gap 3 units, word gap 7 units.

---
 rtl/morse_sequence_player.sv | 137 +++++++++++++
 tb/tb_morse_sequence_player.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_sequence_player.sv
// Keys a 10-bit encoded letter (five 2-bit slots, slot0 first) out as timed
// Morse marks and gaps on a single registered line.
module morse_sequence_player #(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] EncSeq,
  input  logic       Space_EndSeqbar,
  input  logic       SentFlag,
  output logic       Key,
  output logic       Busy,
  output logic       Ready,
  output logic       Done,
  output logic [2:0] SymCount
);

  localparam logic [CNT_W-1:0] DOT_LEN  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LEN = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAIL_LEN = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(4 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_GAP,
    S_TAIL,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       shreg;
  logic             word_space;

  logic             load_sym;
  logic [CNT_W-1:0] load_len;
  logic             next_sym;
  logic [CNT_W-1:0] cur_len;

  // The DECODE step has no state of its own: these lookups let the load edge
  // and the gap-end edge jump straight into the next mark.
  always_comb begin
    load_sym = ~EncSeq[9];
    load_len = EncSeq[8] ? DASH_LEN : DOT_LEN;
    next_sym = ~shreg[7] && (SymCount < 3'd4);
    cur_len  = shreg[8] ? DASH_LEN : DOT_LEN;
  end

  assign Ready = ~Busy;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      word_space <= 1'b0;
      Key        <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      SymCount   <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (SentFlag) begin
            shreg      <= EncSeq;
            word_space <= Space_EndSeqbar;
            SymCount   <= '0;
            Busy       <= 1'b1;
            if (load_sym) begin
              state <= S_MARK;
              Key   <= 1'b1;
              cnt   <= load_len;
            end else if (Space_EndSeqbar) begin
              state <= S_TAIL;
              Key   <= 1'b0;
              cnt   <= WORD_LEN;
            end else begin
              state <= S_DONE;
              Key   <= 1'b0;
              Done  <= 1'b1;
            end
          end
        end
        S_MARK: begin
          if (cnt == '0) begin
            SymCount <= (SymCount == 3'd5) ? 3'd5 : SymCount + 3'd1;
            shreg    <= {shreg[7:0], 2'b10};
            Key      <= 1'b0;
            if (next_sym) begin
              state <= S_GAP;
              cnt   <= GAP_LEN;
            end else if (word_space) begin
              state <= S_TAIL;
              cnt   <= TAIL_LEN;
            end else begin
              state <= S_DONE;
              Done  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_MARK;
            Key   <= 1'b1;
            cnt   <= cur_len;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_TAIL: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Key   <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_sequence_player.sv
// Bench for morse_sequence_player at UNIT_CYCLES=2: a per-cycle expected
// waveform is queued at load time and checked against the DUT every cycle.
module tb_morse_sequence_player;

  localparam int unsigned U = 2;

  logic       Clk;
  logic       Reset;
  logic [9:0] EncSeq;
  logic       Space_EndSeqbar;
  logic       SentFlag;
  logic       Key;
  logic       Busy;
  logic       Ready;
  logic       Done;
  logic [2:0] SymCount;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic       key;
    logic       busy;
    logic       done;
    logic [2:0] sym;
  } exp_t;

  exp_t sb[$];

  morse_sequence_player #(.UNIT_CYCLES(U), .CNT_W(8)) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .EncSeq          (EncSeq),
    .Space_EndSeqbar (Space_EndSeqbar),
    .SentFlag        (SentFlag),
    .Key             (Key),
    .Busy            (Busy),
    .Ready           (Ready),
    .Done            (Done),
    .SymCount        (SymCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void push_n(input int n, input logic k, input logic b,
                                 input logic d, input int s);
    exp_t e;
    e.key  = k;
    e.busy = b;
    e.done = d;
    e.sym  = 3'(s);
    for (int i = 0; i < n; i++) sb.push_back(e);
  endfunction

  // Expected waveform from the cycle after the load edge through the first idle cycle.
  function automatic void build(input logic [9:0] enc, input logic sp);
    int n = 0;
    while (n < 5 && enc[9 - 2 * n] == 1'b0) n++;
    for (int i = 0; i < n; i++) begin
      push_n((enc[8 - 2 * i] ? 3 : 1) * U, 1'b1, 1'b1, 1'b0, i);
      if (i < n - 1) push_n(U, 1'b0, 1'b1, 1'b0, i + 1);
    end
    if (n == 0) begin
      if (sp) push_n(4 * U, 1'b0, 1'b1, 1'b0, 0);
      else    push_n(1, 1'b0, 1'b1, 1'b1, 0);
    end else begin
      if (sp) push_n(3 * U, 1'b0, 1'b1, 1'b0, n);
      else    push_n(1, 1'b0, 1'b1, 1'b1, n);
    end
    push_n(1, 1'b0, 1'b0, 1'b0, n);
  endfunction

  // Plays one letter. preloaded: SentFlag was already driven in the current
  // cycle. chain: drive the next letter during the final idle cycle.
  task automatic play(input string name, input logic [9:0] enc, input logic sp,
                      input int exp_busy, input int exp_sym, input int exp_done,
                      input int glitch_at, input bit preloaded,
                      input bit chain, input logic [9:0] next_enc,
                      input logic next_sp);
    exp_t e;
    int   idx = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    if (!preloaded) begin
      @(negedge Clk);
      EncSeq          = enc;
      Space_EndSeqbar = sp;
      SentFlag        = 1'b1;
    end
    build(enc, sp);
    @(negedge Clk);
    SentFlag = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests_run++;
      if ({Key, Busy, Done, SymCount, Ready} !== {e.key, e.busy, e.done, e.sym, ~e.busy}) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: key/busy/done/sym/ready got %b%b%b %0d %b, expected %b%b%b %0d %b",
                 name, idx, Key, Busy, Done, SymCount, Ready,
                 e.key, e.busy, e.done, e.sym, ~e.busy);
      end
      if (Busy === 1'b1) busy_cnt++;
      if (Done === 1'b1) done_cnt++;
      if (sb.size() == 0) begin
        if (chain) begin
          EncSeq          = next_enc;
          Space_EndSeqbar = next_sp;
          SentFlag        = 1'b1;
        end
      end else begin
        if (idx == glitch_at) begin
          EncSeq          = 10'b00_00_00_00_00;
          Space_EndSeqbar = ~sp;
          SentFlag        = 1'b1;
        end else if (idx == glitch_at + 1) begin
          SentFlag = 1'b0;
        end
        @(negedge Clk);
      end
      idx++;
    end
    tests_run++;
    if (busy_cnt != exp_busy) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, exp_busy);
    end
    tests_run++;
    if (done_cnt != exp_done) begin
      tests_failed++;
      $display("FAIL %s done_pulses: got %0d, expected %0d", name, done_cnt, exp_done);
    end
    tests_run++;
    if (SymCount !== 3'(exp_sym)) begin
      tests_failed++;
      $display("FAIL %s symcount: got %0d, expected %0d", name, SymCount, exp_sym);
    end
  endtask

  task automatic test_reset();
    Reset           = 1'b0;
    EncSeq          = '0;
    Space_EndSeqbar = 1'b0;
    SentFlag        = 1'b0;
    repeat (2) @(negedge Clk);
    tests_run++;
    if ({Key, Busy, Ready, Done, SymCount} !== {1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_state: key/busy/ready/done/sym got %b%b%b%b %0d, expected 0010 0",
               Key, Busy, Ready, Done, SymCount);
    end
    Reset = 1'b1;
  endtask

  task automatic test_letter_l();
    play("letter_L", 10'b00_01_00_00_10, 1'b1, 24, 4, 0, -1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_empty();
    play("empty_space", 10'b10_10_10_10_10, 1'b1, 8, 0, 0, -1, 1'b0, 1'b0, '0, 1'b0);
    play("empty_eom", 10'b11_00_01_10_10, 1'b0, 1, 0, 1, -1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_end_of_message();
    play("L_eom", 10'b00_01_00_00_10, 1'b0, 19, 4, 1, -1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_full_letter();
    play("five_dashes", 10'b01_01_01_01_01, 1'b0, 39, 5, 1, -1, 1'b0, 1'b0, '0, 1'b0);
    play("slots_after_empty", 10'b01_00_10_00_01, 1'b1, 16, 2, 0, -1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_ignore_while_busy();
    play("ignore_busy", 10'b00_01_00_00_10, 1'b1, 24, 4, 0, 5, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    play("b2b_T", 10'b01_10_10_10_10, 1'b1, 12, 1, 0, -1, 1'b0, 1'b1,
         10'b00_10_10_10_10, 1'b0);
    play("b2b_E", 10'b00_10_10_10_10, 1'b0, 3, 1, 1, -1, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid_dash();
    @(negedge Clk);
    EncSeq          = 10'b01_10_10_10_10;
    Space_EndSeqbar = 1'b1;
    SentFlag        = 1'b1;
    @(negedge Clk);
    SentFlag = 1'b0;
    tests_run++;
    if ({Key, Busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL mid_dash_start: key/busy got %b%b, expected 11", Key, Busy);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    tests_run++;
    if ({Key, Busy, Ready, Done, SymCount} !== {1'b0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      tests_failed++;
      $display("FAIL reset_mid_dash: key/busy/ready/done/sym got %b%b%b%b %0d, expected 0010 0",
               Key, Busy, Ready, Done, SymCount);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    play("after_reset", 10'b00_01_00_00_10, 1'b1, 24, 4, 0, -1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_letter_l();
    test_empty();
    test_end_of_message();
    test_full_letter();
    test_ignore_while_busy();
    test_back_to_back();
    test_reset_mid_dash();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
